// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, with tagged read return.
// Optional perf counters behind MEM_ARB_PERF_CNT_EN; latency check skipped under UTOSS_RISCV_SYNTHESIS.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0,
   input  logic [ADDR_W-1:0]   addr0,
   input  logic [DATA_W-1:0]   wdata0,
   input  logic [DATA_W/8-1:0] wstrb0,
   input  logic                req1,
   input  logic [ADDR_W-1:0]   addr1,
   input  logic [DATA_W-1:0]   wdata1,
   input  logic [DATA_W/8-1:0] wstrb1,
   output logic                gnt0,
   output logic                gnt1,
   output logic                rvalid0,
   output logic                rvalid1,
   output logic [DATA_W-1:0]   rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_we,
   output logic                mem_re,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   input  logic                perf_clr,
   output logic [31:0]         perf_gnt0,
   output logic [31:0]         perf_gnt1,
   output logic [31:0]         perf_conflict
`endif
);

   localparam int STRB_W = DATA_W / 8;

`ifndef UTOSS_RISCV_SYNTHESIS
   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
         $fatal(1, "mem_port_arbiter: READ_LATENCY must be within 1..4");
      end
   endgenerate
`endif

   logic                    last_grant_r;
   logic [READ_LATENCY-1:0] valid_r;
   logic [READ_LATENCY-1:0] port_r;
   logic                    gnt0_s;
   logic                    gnt1_s;
   logic [ADDR_W-1:0]       mem_addr_s;
   logic [DATA_W-1:0]       mem_wdata_s;
   logic [STRB_W-1:0]       mem_we_s;
   logic                    mem_re_s;

   // Grant decision: a lone requester wins, a conflict goes to the port that did not win last.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (reset) begin
         gnt0_s = req0 && (!req1 || last_grant_r);
         gnt1_s = req1 && (!req0 || !last_grant_r);
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Steer the granted port onto the memory bus; idle bus is all zero.
   always_comb begin
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = {DATA_W{1'b0}};
      mem_we_s    = {STRB_W{1'b0}};
      mem_re_s    = 1'b0;
      case ({gnt1_s, gnt0_s})
         2'b01: begin
            mem_addr_s  = addr0;
            mem_wdata_s = wdata0;
            mem_we_s    = wstrb0;
            mem_re_s    = (wstrb0 == {STRB_W{1'b0}});
         end
         2'b10: begin
            mem_addr_s  = addr1;
            mem_wdata_s = wdata1;
            mem_we_s    = wstrb1;
            mem_re_s    = (wstrb1 == {STRB_W{1'b0}});
         end
         default: begin
            mem_addr_s  = {ADDR_W{1'b0}};
            mem_wdata_s = {DATA_W{1'b0}};
            mem_we_s    = {STRB_W{1'b0}};
            mem_re_s    = 1'b0;
         end
      endcase
   end

   // Round-robin history and the read-return tag pipeline.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_r <= 1'b1;
         valid_r      <= {READ_LATENCY{1'b0}};
         port_r       <= {READ_LATENCY{1'b0}};
      end else begin
         if (gnt0_s) begin
            last_grant_r <= 1'b0;
         end else if (gnt1_s) begin
            last_grant_r <= 1'b1;
         end
         valid_r[0] <= mem_re_s;
         port_r[0]  <= gnt1_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_r[i] <= valid_r[i-1];
            port_r[i]  <= port_r[i-1];
         end
      end
   end

   assign gnt0      = gnt0_s;
   assign gnt1      = gnt1_s;
   assign mem_addr  = mem_addr_s;
   assign mem_wdata = mem_wdata_s;
   assign mem_we    = mem_we_s;
   assign mem_re    = mem_re_s;
   assign rvalid0   = valid_r[READ_LATENCY-1] && !port_r[READ_LATENCY-1];
   assign rvalid1   = valid_r[READ_LATENCY-1] &&  port_r[READ_LATENCY-1];
   assign rdata     = mem_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_gnt0_r;
   logic [31:0] perf_gnt1_r;
   logic [31:0] perf_conflict_r;

   // Grant and conflict counters; a clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_gnt0_r     <= 32'd0;
         perf_gnt1_r     <= 32'd0;
         perf_conflict_r <= 32'd0;
      end else if (perf_clr) begin
         perf_gnt0_r     <= 32'd0;
         perf_gnt1_r     <= 32'd0;
         perf_conflict_r <= 32'd0;
      end else begin
         if (gnt0_s) perf_gnt0_r <= perf_gnt0_r + 32'd1;
         if (gnt1_s) perf_gnt1_r <= perf_gnt1_r + 32'd1;
         if (req0 && req1) perf_conflict_r <= perf_conflict_r + 32'd1;
      end
   end

   assign perf_gnt0     = perf_gnt0_r;
   assign perf_gnt1     = perf_gnt1_r;
   assign perf_conflict = perf_conflict_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at READ_LATENCY 1, 2 and 3 share stimulus.
// Counter checks are compiled in only when MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [3:0]  wstrb0, wstrb1;

   logic gnt0_1, gnt1_1, rv0_1, rv1_1, mre_1;
   logic gnt0_2, gnt1_2, rv0_2, rv1_2, mre_2;
   logic gnt0_3, gnt1_3, rv0_3, rv1_3, mre_3;
   logic [31:0] rdata_1, maddr_1, mwdata_1, mrdata_1;
   logic [31:0] rdata_2, maddr_2, mwdata_2, mrdata_2;
   logic [31:0] rdata_3, maddr_3, mwdata_3, mrdata_3;
   logic [3:0]  mwe_1, mwe_2, mwe_3;
   logic [31:0] p2 [2];
   logic [31:0] p3 [3];

`ifdef MEM_ARB_PERF_CNT_EN
   logic        perf_clr;
   logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.READ_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .wdata0(wdata0), .wstrb0(wstrb0),
      .req1(req1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1),
      .gnt0(gnt0_1), .gnt1(gnt1_1), .rvalid0(rv0_1), .rvalid1(rv1_1), .rdata(rdata_1),
      .mem_addr(maddr_1), .mem_wdata(mwdata_1), .mem_we(mwe_1), .mem_re(mre_1),
      .mem_rdata(mrdata_1)
`ifdef MEM_ARB_PERF_CNT_EN
      , .perf_clr(perf_clr), .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1),
      .perf_conflict(perf_conflict)
`endif
   );

   mem_port_arbiter #(.READ_LATENCY(2)) u_dut2 (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .wdata0(wdata0), .wstrb0(wstrb0),
      .req1(req1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1),
      .gnt0(gnt0_2), .gnt1(gnt1_2), .rvalid0(rv0_2), .rvalid1(rv1_2), .rdata(rdata_2),
      .mem_addr(maddr_2), .mem_wdata(mwdata_2), .mem_we(mwe_2), .mem_re(mre_2),
      .mem_rdata(mrdata_2)
`ifdef MEM_ARB_PERF_CNT_EN
      , .perf_clr(perf_clr), .perf_gnt0(), .perf_gnt1(), .perf_conflict()
`endif
   );

   mem_port_arbiter #(.READ_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .wdata0(wdata0), .wstrb0(wstrb0),
      .req1(req1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1),
      .gnt0(gnt0_3), .gnt1(gnt1_3), .rvalid0(rv0_3), .rvalid1(rv1_3), .rdata(rdata_3),
      .mem_addr(maddr_3), .mem_wdata(mwdata_3), .mem_we(mwe_3), .mem_re(mre_3),
      .mem_rdata(mrdata_3)
`ifdef MEM_ARB_PERF_CNT_EN
      , .perf_clr(perf_clr), .perf_gnt0(), .perf_gnt1(), .perf_conflict()
`endif
   );

   // Memory contents: one fixed word at 0x100, otherwise a tag derived from the address.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      else return {16'hA5A5, a[15:0]};
   endfunction

   // Memory models with 1, 2 and 3 cycles of read latency.
   always_ff @(posedge clk) begin
      mrdata_1 <= mem_val(maddr_1);
      p2[0]    <= mem_val(maddr_2);
      p2[1]    <= p2[0];
      p3[0]    <= mem_val(maddr_3);
      p3[1]    <= p3[0];
      p3[2]    <= p3[1];
   end
   assign mrdata_2 = p2[1];
   assign mrdata_3 = p3[2];

   task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1);
      @(negedge clk);
      req0 = r0; addr0 = a0; wstrb0 = 4'd0;
      req1 = r1; addr1 = a1; wstrb1 = 4'd0;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      req0 = 1'b1; addr0 = 32'h100; wdata0 = 32'h0; wstrb0 = 4'd0;
      req1 = 1'b1; addr1 = 32'h20;  wdata1 = 32'h0; wstrb1 = 4'd0;
`ifdef MEM_ARB_PERF_CNT_EN
      perf_clr = 1'b0;
`endif
      #2;
      check_vec("rst_gnt0", 32'(gnt0_1), 32'd0);
      check_vec("rst_gnt1", 32'(gnt1_1), 32'd0);
      check_vec("rst_mem_re", 32'(mre_1), 32'd0);
      check_vec("rst_mem_addr", maddr_1, 32'd0);
      check_vec("rst_rvalid0", 32'(rv0_1), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      reset = 1'b1;

      // Single port-0 read at latency 1
      drive(1'b1, 32'h100, 1'b0, 32'h0);
      check_vec("rd_gnt0", 32'(gnt0_1), 32'd1);
      check_vec("rd_gnt1", 32'(gnt1_1), 32'd0);
      check_vec("rd_mem_re", 32'(mre_1), 32'd1);
      check_vec("rd_mem_addr", maddr_1, 32'h100);
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      check_vec("rd_rvalid0", 32'(rv0_1), 32'd1);
      check_vec("rd_rdata", rdata_1, 32'hDEAD_BEEF);
      check_vec("rd_rvalid1", 32'(rv1_1), 32'd0);
      check_vec("idle_gnt0", 32'(gnt0_1), 32'd0);

      // Reset pulse so the conflict sequence starts from a fresh last_grant
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;

      // Four conflict cycles: grants alternate 0,1,0,1 with tagged returns
      for (int i = 0; i < 5; i++) begin
         drive(i < 4, 32'h10, i < 4, 32'h20);
         if (i < 4) begin
            check_vec($sformatf("cf_gnt0_%0d", i), 32'(gnt0_1), 32'((i % 2) == 0));
            check_vec($sformatf("cf_gnt1_%0d", i), 32'(gnt1_1), 32'((i % 2) == 1));
            check_vec($sformatf("cf_addr_%0d", i), maddr_1, ((i % 2) == 0) ? 32'h10 : 32'h20);
         end
         if (i > 0) begin
            check_vec($sformatf("cf_rv0_%0d", i), 32'(rv0_1), 32'((i % 2) == 1));
            check_vec($sformatf("cf_rv1_%0d", i), 32'(rv1_1), 32'((i % 2) == 0));
            check_vec($sformatf("cf_rdata_%0d", i), rdata_1,
                      ((i % 2) == 1) ? 32'hA5A5_0010 : 32'hA5A5_0020);
         end
      end

      // Port-1 partial write: no read strobe, no return
      drive(1'b0, 32'h0, 1'b1, 32'h40);
      wstrb1 = 4'b0011; wdata1 = 32'h1234_5678;
      #1;
      check_vec("wr_gnt1", 32'(gnt1_1), 32'd1);
      check_vec("wr_mem_we", 32'(mwe_1), 32'h3);
      check_vec("wr_mem_re", 32'(mre_1), 32'd0);
      check_vec("wr_mem_wdata", mwdata_1, 32'h1234_5678);
      check_vec("wr_mem_addr", maddr_1, 32'h40);
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      wdata1 = 32'h0;
      check_vec("wr_rvalid0", 32'(rv0_1), 32'd0);
      check_vec("wr_rvalid1", 32'(rv1_1), 32'd0);

      // Latency 3: four back-to-back port-0 reads return on consecutive cycles in order
      for (int i = 0; i < 8; i++) begin
         drive(i < 4, 32'h200 + 32'(4 * i), 1'b0, 32'h0);
         if (i < 4) check_vec($sformatf("l3_gnt0_%0d", i), 32'(gnt0_3), 32'd1);
         check_vec($sformatf("l3_rv0_%0d", i), 32'(rv0_3), 32'(i >= 3 && i <= 6));
         check_vec($sformatf("l3_rv1_%0d", i), 32'(rv1_3), 32'd0);
         if (i >= 3 && i <= 6)
            check_vec($sformatf("l3_rdata_%0d", i), rdata_3, 32'hA5A5_0200 + 32'(4 * (i - 3)));
      end

      // Latency 2: reset one cycle after a read grant drops the read and restores priority
      drive(1'b1, 32'h300, 1'b0, 32'h0);
      check_vec("rr_gnt0", 32'(gnt0_2), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 32'h20);
      reset = 1'b0;
      #1;
      check_vec("rr_gnt1_in_rst", 32'(gnt1_2), 32'd0);
      check_vec("rr_mem_re_in_rst", 32'(mre_2), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_vec($sformatf("rr_rv0_%0d", i), 32'(rv0_2), 32'd0);
         check_vec($sformatf("rr_rv1_%0d", i), 32'(rv1_2), 32'd0);
         drive(1'b0, 32'h0, 1'b0, 32'h0);
      end
      drive(1'b1, 32'h10, 1'b1, 32'h20);
      check_vec("rr_cf_gnt0", 32'(gnt0_2), 32'd1);
      check_vec("rr_cf_gnt1", 32'(gnt1_2), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 32'h0);

`ifdef MEM_ARB_PERF_CNT_EN
      // Counters: 2 conflicts (0 then 1), four port-0 and two port-1 solo grants
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 8; i++)
         drive(i < 6, 32'h10, (i < 2) || (i >= 6), 32'h20);
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      check_vec("pc_gnt0", perf_gnt0, 32'd5);
      check_vec("pc_gnt1", perf_gnt1, 32'd3);
      check_vec("pc_conflict", perf_conflict, 32'd2);
      drive(1'b1, 32'h10, 1'b0, 32'h0);
      perf_clr = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      perf_clr = 1'b0;
      check_vec("pc_clr_gnt0", perf_gnt0, 32'd0);
      check_vec("pc_clr_gnt1", perf_gnt1, 32'd0);
      check_vec("pc_clr_conflict", perf_conflict, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
